ppu_timing: RTL

//  Parametrised raster timing generator for the PPU. Owns the dot/line counters,
//  odd-frame flag, vblank flag, NMI level and output-pixel window. Adds what the

---
 rtl/ppu_timing_if.sv | 29 ++
 rtl/ppu_timing.sv | 99 +++++++++
 2 files changed

// File: rtl/ppu_timing_if.sv
// Raster timing bundle between the PPU register block / video pipeline and ppu_timing.
// The slave modport is the timing generator side; master is the consumer/driver side.
interface ppu_timing_if;
  logic       tick;
  logic       pal;
  logic       render_en;
  logic       nmi_en;
  logic       rd2002;
  logic [8:0] ppux;
  logic [8:0] ppuy;
  logic       odd;
  logic       vbl;
  logic       render;
  logic       nmi;
  logic       frame_start;
  logic [8:0] outx;
  logic [8:0] outy;
  logic       pxvalid;

  modport slave (
    input  tick, pal, render_en, nmi_en, rd2002,
    output ppux, ppuy, odd, vbl, render, nmi, frame_start, outx, outy, pxvalid
  );

  modport master (
    output tick, pal, render_en, nmi_en, rd2002,
    input  ppux, ppuy, odd, vbl, render, nmi, frame_start, outx, outy, pxvalid
  );
endinterface

// File: rtl/ppu_timing.sv
// PPU raster timing generator: dot/line counters, odd-frame skip, NTSC/PAL line count,
// vblank flag with $2002 read race suppression, NMI level and delayed output-pixel window.
module ppu_timing #(
  parameter int unsigned HTOTAL    = 341,
  parameter int unsigned VTOT_NTSC = 262,
  parameter int unsigned VTOT_PAL  = 312,
  parameter int unsigned VIS_LINES = 240,
  parameter int unsigned VBL_LINE  = 241,
  parameter int unsigned OUT_DELAY = 4
) (
  input logic           clk,
  input logic           reset,
  ppu_timing_if.slave   bus
);

  localparam logic [8:0] XLast   = 9'(HTOTAL - 1);
  localparam logic [8:0] XSkip   = 9'(HTOTAL - 2);
  localparam logic [8:0] PreNtsc = 9'(VTOT_NTSC - 1);
  localparam logic [8:0] PrePal  = 9'(VTOT_PAL - 1);
  localparam logic [8:0] VisEnd  = 9'(VIS_LINES);
  localparam logic [8:0] VblY    = 9'(VBL_LINE);
  localparam logic [8:0] OutDly  = 9'(OUT_DELAY);
  localparam logic [9:0] PxBeg   = 10'(OUT_DELAY);
  localparam logic [9:0] PxEnd   = 10'(OUT_DELAY + 256);

  logic [8:0] x_q, x_d, y_q, y_d;
  logic       odd_q, odd_d, vbl_q, vbl_d, mode_q, mode_d, fs_q, fs_d, sup_q, sup_d;
  logic [8:0] pre;
  logic       rd, skip, wrap, vbl_set, vbl_clr, race;

  always_comb begin
    pre  = mode_q ? PrePal : PreNtsc;
    rd   = bus.tick & bus.rd2002;
    // NTSC odd frames drop the last dot of the pre-render line while rendering
    skip = ~mode_q & odd_q & bus.render_en & (y_q == pre) & (x_q == XSkip);
    wrap = ((x_q == XLast) & (y_q == pre)) | skip;

    x_d    = x_q;
    y_d    = y_q;
    odd_d  = odd_q;
    mode_d = mode_q;
    fs_d   = fs_q;
    if (bus.tick) begin
      fs_d = 1'b0;
      if (wrap) begin
        x_d    = '0;
        y_d    = '0;
        odd_d  = ~odd_q;
        fs_d   = 1'b1;
        mode_d = bus.pal;
      end else if (x_q == XLast) begin
        x_d = '0;
        y_d = y_q + 9'd1;
      end else begin
        x_d = x_q + 9'd1;
      end
    end

    // A read landing on dot 0/1 of the vblank line hides that frame's vblank
    race    = rd & (y_q == VblY) & ((x_q == 9'd0) | (x_q == 9'd1));
    vbl_set = bus.tick & (x_q == 9'd0) & (y_q == VblY) & ~sup_q;
    vbl_clr = (bus.tick & (x_q == 9'd0) & (y_q == pre)) | rd;
    vbl_d   = vbl_clr ? 1'b0 : (vbl_set ? 1'b1 : vbl_q);
    sup_d   = race ? 1'b1 : ((bus.tick & (y_q == pre)) ? 1'b0 : sup_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q    <= '0;
      y_q    <= '0;
      odd_q  <= 1'b0;
      vbl_q  <= 1'b0;
      mode_q <= 1'b0;
      fs_q   <= 1'b0;
      sup_q  <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      odd_q  <= odd_d;
      vbl_q  <= vbl_d;
      mode_q <= mode_d;
      fs_q   <= fs_d;
      sup_q  <= sup_d;
    end
  end

  assign bus.ppux        = x_q;
  assign bus.ppuy        = y_q;
  assign bus.odd         = odd_q;
  assign bus.vbl         = vbl_q;
  assign bus.frame_start = fs_q;
  assign bus.nmi         = vbl_q & bus.nmi_en;
  assign bus.render      = bus.render_en & ((y_q < VisEnd) | (y_q == pre));
  assign bus.outx        = x_q - OutDly;
  assign bus.outy        = y_q;
  assign bus.pxvalid     = bus.tick & (y_q < VisEnd) & ({1'b0, x_q} >= PxBeg) &
                           ({1'b0, x_q} < PxEnd);

endmodule
